// File: rtl/icache_line_prefetcher_pkg.sv
// Shared definitions for the next-line instruction prefetcher.
package icache_line_prefetcher_pkg;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_AR,
    PF_R
  } pf_state_e;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam int DEF_LINE_WORDS = 16;
  localparam int LINE_OFF_BITS  = $clog2(DEF_LINE_WORDS * 4);

  // Address of the line after the one containing addr; wraps modulo 2^32.
  function automatic logic [31:0] next_line_addr(input logic [31:0] addr,
                                                 input int unsigned off_bits);
    logic [31:0] line_bytes;
    line_bytes = 32'd1 << off_bits;
    return (addr + line_bytes) & ~(line_bytes - 32'd1);
  endfunction

endpackage

// File: rtl/icache_line_prefetcher_line_buffer.sv
// Single prefetch line: word-addressed write port, flat read-out, clear to zero.
module pf_line_buffer #(
  parameter int WORDS = 16,
  parameter int IDXW  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  we_i,
  input  logic [IDXW-1:0]       idx_i,
  input  logic [31:0]           wdata_i,
  output logic [32*WORDS-1:0]   data_o
);

  logic [31:0] mem_q [WORDS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  for (genvar g = 0; g < WORDS; g++) begin : g_flat
    assign data_o[32*g +: 32] = mem_q[g];
  end

endmodule

// File: rtl/icache_line_prefetcher.sv
// Next-line instruction prefetcher: one INCR burst per qualifying miss into a
// single-entry line buffer, read-only AXI master.
//
// state   | meaning
// PF_IDLE | no burst outstanding; buffer stable
// PF_AR   | read address presented, waiting for arready
// PF_R    | receiving beats; aborted bursts are drained then reissued
module icache_line_prefetcher
  import icache_line_prefetcher_pkg::*;
#(
  parameter int         LINE_WORDS = DEF_LINE_WORDS,
  parameter logic [3:0] AXI_ID     = 4'd1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    miss_i,
  input  logic                    rd_req_i,
  input  logic [31:0]             rd_addr_i,
  input  logic                    next_present_i,
  input  logic                    consume_i,
  output logic [31:0]             buff_addr_o,
  output logic [32*LINE_WORDS-1:0] buff_data_o,
  output logic                    buff_ready_o,
  output logic                    busy_o,
  output logic [3:0]              arid_o,
  output logic [31:0]             araddr_o,
  output logic [3:0]              arlen_o,
  output logic [2:0]              arsize_o,
  output logic [1:0]              arburst_o,
  output logic [1:0]              arlock_o,
  output logic [3:0]              arcache_o,
  output logic [2:0]              arprot_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [3:0]              rid_i,
  input  logic [31:0]             rdata_i,
  input  logic [1:0]              rresp_i,
  input  logic                    rlast_i,
  input  logic                    rvalid_i,
  output logic                    rready_o,
  output logic [3:0]              awid_o,
  output logic [31:0]             awaddr_o,
  output logic [3:0]              awlen_o,
  output logic [2:0]              awsize_o,
  output logic [1:0]              awburst_o,
  output logic [1:0]              awlock_o,
  output logic [3:0]              awcache_o,
  output logic [2:0]              awprot_o,
  output logic                    awvalid_o,
  output logic [31:0]             wdata_o,
  output logic [3:0]              wstrb_o,
  output logic                    wlast_o,
  output logic                    wvalid_o,
  output logic                    bready_o
);

  localparam int OFF_BITS = (LINE_WORDS == DEF_LINE_WORDS) ? LINE_OFF_BITS
                                                           : $clog2(LINE_WORDS * 4);
  localparam int IDXW     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  pf_state_e       state_q, state_d;
  logic [31:0]     pend_addr_q, pend_addr_d;
  logic [31:0]     next_addr_q, next_addr_d;
  logic [31:0]     buff_addr_q, buff_addr_d;
  logic            buff_ready_q, buff_ready_d;
  logic            err_q, err_d;
  logic            abort_q, abort_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic            buf_clr, buf_we;
  logic [31:0]     tgt;
  logic            trigger;
  logic            beat;

  assign tgt     = next_line_addr(rd_addr_i, OFF_BITS);
  assign trigger = rd_req_i & miss_i & ~next_present_i &
                   ((tgt != buff_addr_q) | ~buff_ready_q);
  // Beats carrying another ID are handshaken but never land in the buffer.
  assign beat    = (state_q == PF_R) & rvalid_i & (rid_i == AXI_ID);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= PF_IDLE;
      pend_addr_q  <= '0;
      next_addr_q  <= '0;
      buff_addr_q  <= '0;
      buff_ready_q <= 1'b0;
      err_q        <= 1'b0;
      abort_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_addr_q  <= pend_addr_d;
      next_addr_q  <= next_addr_d;
      buff_addr_q  <= buff_addr_d;
      buff_ready_q <= buff_ready_d;
      err_q        <= err_d;
      abort_q      <= abort_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_addr_d  = pend_addr_q;
    next_addr_d  = next_addr_q;
    buff_addr_d  = buff_addr_q;
    buff_ready_d = buff_ready_q;
    err_d        = err_q;
    abort_d      = abort_q;
    cnt_d        = cnt_q;
    buf_clr      = 1'b0;
    buf_we       = 1'b0;
    case (state_q)
      PF_IDLE: begin
        if (consume_i) buff_ready_d = 1'b0;
        if (trigger) begin
          pend_addr_d = tgt;
          state_d     = PF_AR;
        end
      end
      PF_AR: begin
        if (arready_i) begin
          state_d      = PF_R;
          cnt_d        = '0;
          err_d        = 1'b0;
          abort_d      = 1'b0;
          buff_ready_d = 1'b0;
          buf_clr      = 1'b1;
        end
      end
      PF_R: begin
        if (trigger && (tgt != pend_addr_q)) begin
          abort_d     = 1'b1;
          next_addr_d = tgt;
        end
        if (beat) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          err_d  = err_q | (|rresp_i);
          if (rlast_i) begin
            // AXI cannot cancel a burst, so a superseded line is drained and dropped.
            if (abort_d) begin
              pend_addr_d = next_addr_d;
              state_d     = PF_AR;
            end else begin
              buff_addr_d  = pend_addr_q;
              buff_ready_d = ~err_d;
              state_d      = PF_IDLE;
            end
          end
        end
      end
      default: state_d = PF_IDLE;
    endcase
  end

  pf_line_buffer #(
    .WORDS (LINE_WORDS),
    .IDXW  (IDXW)
  ) u_line_buffer (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .clr_i   (buf_clr),
    .we_i    (buf_we),
    .idx_i   (cnt_q),
    .wdata_i (rdata_i),
    .data_o  (buff_data_o)
  );

  assign buff_addr_o  = buff_addr_q;
  assign buff_ready_o = buff_ready_q;
  assign busy_o       = (state_q != PF_IDLE);

  assign arid_o    = AXI_ID;
  assign araddr_o  = pend_addr_q;
  assign arlen_o   = 4'(LINE_WORDS - 1);
  assign arsize_o  = AXI_SIZE_4B;
  assign arburst_o = AXI_BURST_INCR;
  assign arlock_o  = 2'b00;
  assign arcache_o = 4'b0000;
  assign arprot_o  = 3'b000;
  assign arvalid_o = (state_q == PF_AR);
  assign rready_o  = (state_q == PF_R);

  assign awid_o    = '0;
  assign awaddr_o  = '0;
  assign awlen_o   = '0;
  assign awsize_o  = '0;
  assign awburst_o = '0;
  assign awlock_o  = '0;
  assign awcache_o = '0;
  assign awprot_o  = '0;
  assign awvalid_o = 1'b0;
  assign wdata_o   = '0;
  assign wstrb_o   = '0;
  assign wlast_o   = 1'b0;
  assign wvalid_o  = 1'b0;
  assign bready_o  = 1'b0;

endmodule

// File: tb/tb_icache_line_prefetcher.sv
// Directed bench for icache_line_prefetcher: expected AR addresses and completed
// lines are queued by the stimulus and checked by an independent monitor.
module tb_icache_line_prefetcher;

  localparam int LW = 16;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic miss, rd_req, next_present, consume;
  logic [31:0] rd_addr;
  logic [31:0] buff_addr;
  logic [32*LW-1:0] buff_data;
  logic buff_ready, busy;
  logic [3:0] arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0] arsize, arprot;
  logic [1:0] arburst, arlock;
  logic arvalid, arready;
  logic [3:0] rid;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rlast, rvalid, rready;
  logic [3:0] awid, awlen, awcache, wstrb;
  logic [31:0] awaddr, wdata;
  logic [2:0] awsize, awprot;
  logic [1:0] awburst, awlock;
  logic awvalid, wlast, wvalid, bready;

  icache_line_prefetcher dut (
    .aclk(aclk), .aresetn(aresetn), .miss_i(miss), .rd_req_i(rd_req),
    .rd_addr_i(rd_addr), .next_present_i(next_present), .consume_i(consume),
    .buff_addr_o(buff_addr), .buff_data_o(buff_data), .buff_ready_o(buff_ready),
    .busy_o(busy), .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen),
    .arsize_o(arsize), .arburst_o(arburst), .arlock_o(arlock), .arcache_o(arcache),
    .arprot_o(arprot), .arvalid_o(arvalid), .arready_i(arready), .rid_i(rid),
    .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast), .rvalid_i(rvalid),
    .rready_o(rready), .awid_o(awid), .awaddr_o(awaddr), .awlen_o(awlen),
    .awsize_o(awsize), .awburst_o(awburst), .awlock_o(awlock), .awcache_o(awcache),
    .awprot_o(awprot), .awvalid_o(awvalid), .wdata_o(wdata), .wstrb_o(wstrb),
    .wlast_o(wlast), .wvalid_o(wvalid), .bready_o(bready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] base;
  } line_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rlast_cyc = -10;
  logic br_prev = 1'b0;
  logic [31:0] ar_q[$];
  line_t line_q[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] exp_line(input logic [31:0] base);
    logic [511:0] v;
    for (int i = 0; i < LW; i++) v[32*i +: 32] = base + 32'(i);
    return v;
  endfunction

  always @(posedge aclk) cyc <= cyc + 1;

  // Monitor: consumes expectations whenever the DUT presents an AR or a finished line.
  always @(negedge aclk) begin
    line_t l;
    if (aresetn) begin
      if (arvalid && arready) begin
        if (ar_q.size() == 0) begin
          total++; bad++;
          $display("FAIL ar_unexpected: got araddr %0h expected no request", araddr);
        end else begin
          chk("araddr", araddr, ar_q.pop_front());
        end
        chk("ar_fields", {arid, arlen, arsize, arburst, arlock, arcache, arprot},
            {4'd1, 4'd15, 3'b010, 2'b01, 2'b00, 4'd0, 3'd0});
      end
      if (rvalid && rready && rlast && rid == 4'd1) rlast_cyc = cyc;
      if (buff_ready && !br_prev) begin
        if (line_q.size() == 0) begin
          total++; bad++;
          $display("FAIL line_unexpected: got buff_ready with addr %0h expected none", buff_addr);
        end else begin
          l = line_q.pop_front();
          chk("buff_addr", buff_addr, l.addr);
          chk("buff_data", buff_data, exp_line(l.base));
          chk("ready_latency", 32'(cyc - rlast_cyc), 32'd1);
        end
      end
    end
    br_prev = buff_ready;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic fetch_miss(input logic [31:0] a, input logic np, input logic cons);
    rd_req = 1'b1; miss = 1'b1; rd_addr = a; next_present = np; consume = cons;
    tick();
    rd_req = 1'b0; miss = 1'b0; next_present = 1'b0; consume = 1'b0;
  endtask

  task automatic ar_accept(input int delay);
    int n = 0;
    while (!arvalid && n < 20) begin
      tick();
      n++;
    end
    if (!arvalid) begin
      total++; bad++;
      $display("FAIL ar_timeout: got arvalid 0 expected 1");
    end else begin
      repeat (delay) tick();
      arready = 1'b1;
      tick();
      arready = 1'b0;
    end
  endtask

  task automatic beats(input logic [31:0] base, input int nbeats, input int err_beat,
                       input int miss_beat, input logic [31:0] miss_addr);
    for (int i = 0; i < nbeats; i++) begin
      rvalid = 1'b1; rid = 4'd1; rdata = base + 32'(i);
      rresp = (i == err_beat) ? 2'b10 : 2'b00;
      rlast = (i == LW - 1);
      if (i == miss_beat) begin
        rd_req = 1'b1; miss = 1'b1; rd_addr = miss_addr;
      end
      tick();
      rd_req = 1'b0; miss = 1'b0;
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  initial begin
    miss = 0; rd_req = 0; next_present = 0; consume = 0; rd_addr = '0;
    arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
    repeat (3) tick();
    chk("rst_ctrl", {buff_ready, arvalid, rready, busy}, 4'b0000);
    chk("rst_addr", buff_addr, 32'h0);
    chk("rst_data", buff_data, 512'h0);
    chk("aw_tieoff", {awvalid, wvalid, bready, wstrb, awlen}, 11'h0);
    aresetn = 1'b1;
    tick();

    // 1: basic next-line fetch
    ar_q.push_back(32'h1FC0_0040);
    line_q.push_back('{addr: 32'h1FC0_0040, base: 32'h100});
    fetch_miss(32'h1FC0_0000, 1'b0, 1'b0);
    chk("t1_arvalid", arvalid, 1'b1);
    ar_accept(2);
    beats(32'h100, LW, -1, -1, 32'h0);
    chk("t1_ready", buff_ready, 1'b1);
    chk("t1_word5", buff_data[5*32 +: 32], 32'h105);

    // 2: next line already present, then miss matching the buffer
    fetch_miss(32'h1FC0_0000, 1'b1, 1'b0);
    repeat (3) tick();
    chk("t2_np_idle", {arvalid, busy}, 2'b00);
    fetch_miss(32'h1FC0_0000, 1'b0, 1'b0);
    tick();
    chk("t2_hit_idle", {arvalid, busy}, 2'b00);

    // 7a: consume clears ready, address held
    consume = 1'b1;
    tick();
    consume = 1'b0;
    chk("t7_consume", buff_ready, 1'b0);
    chk("t7_addr_hold", buff_addr, 32'h1FC0_0040);

    // 3: abort mid-burst, drain, reissue newest target
    ar_q.push_back(32'h0000_1040);
    ar_q.push_back(32'h0000_2040);
    line_q.push_back('{addr: 32'h0000_2040, base: 32'h300});
    fetch_miss(32'h0000_1000, 1'b0, 1'b0);
    ar_accept(0);
    beats(32'h200, LW, -1, 7, 32'h0000_2000);
    chk("t3_discard", buff_ready, 1'b0);
    chk("t3_reissue", arvalid, 1'b1);
    ar_accept(1);
    beats(32'h300, LW, -1, -1, 32'h0);
    chk("t3_addr", buff_addr, 32'h0000_2040);

    // 4: error response on beat 9
    ar_q.push_back(32'h0000_3040);
    fetch_miss(32'h0000_3000, 1'b0, 1'b0);
    ar_accept(0);
    beats(32'h600, LW, 9, -1, 32'h0);
    chk("t4_err_ready", buff_ready, 1'b0);
    chk("t4_idle", busy, 1'b0);

    // 5: address wrap
    ar_q.push_back(32'h0000_0000);
    line_q.push_back('{addr: 32'h0000_0000, base: 32'h400});
    fetch_miss(32'hFFFF_FFC4, 1'b0, 1'b0);
    ar_accept(0);
    beats(32'h400, LW, -1, -1, 32'h0);
    chk("t5_ready", buff_ready, 1'b1);

    // 7b: consume coincident with a trigger
    ar_q.push_back(32'h0000_5040);
    line_q.push_back('{addr: 32'h0000_5040, base: 32'h500});
    fetch_miss(32'h0000_5000, 1'b0, 1'b1);
    chk("t7b_ready", buff_ready, 1'b0);
    chk("t7b_ar", arvalid, 1'b1);
    ar_accept(0);
    beats(32'h500, LW, -1, -1, 32'h0);

    // 6: reset mid-burst, then a fresh request
    ar_q.push_back(32'h0000_6040);
    fetch_miss(32'h0000_6000, 1'b0, 1'b0);
    ar_accept(0);
    beats(32'h700, 4, -1, -1, 32'h0);
    aresetn = 1'b0;
    #1;
    chk("t6_rst_ctrl", {buff_ready, arvalid, rready, busy}, 4'b0000);
    chk("t6_rst_addr", {buff_addr, araddr}, 64'h0);
    chk("t6_rst_data", buff_data, 512'h0);
    tick();
    aresetn = 1'b1;
    tick();
    ar_q.push_back(32'h0000_7040);
    line_q.push_back('{addr: 32'h0000_7040, base: 32'h800});
    fetch_miss(32'h0000_7000, 1'b0, 1'b0);
    chk("t6_fresh_ar", arvalid, 1'b1);
    ar_accept(0);
    beats(32'h800, LW, -1, -1, 32'h0);
    chk("t6_ready", buff_ready, 1'b1);

    repeat (3) tick();
    chk("ar_q_drained", 32'(ar_q.size()), 32'd0);
    chk("line_q_drained", 32'(line_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
